// File: rtl/rv_pkg.sv
// Shared integer-core constants and types for the register file and its scoreboard.
// The modules take these as parameter defaults so a single build can mix widths.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, an incrementally tracked
// pending count, and per-read-port busy flags that a same-cycle writeback clears.
module rf_scoreboard #(
    parameter int  NREG     = rv_pkg::NREG,
    parameter int  NRP      = 2,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NRP*AW-1:0] raddr,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    output logic [NRP-1:0]  rbusy,
    output logic [AW:0]     pend_cnt
);

    localparam logic [AW:0] CNT_ONE = 1;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic            rsv_ok;
    logic            wb_ok;
    logic            cnt_inc;
    logic            cnt_dec;

    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);
    assign wb_ok  = wb_en  && !(ZERO_REG && wb_addr  == '0);

    // A reservation and a writeback to the same register leave it pending, so the
    // writeback only counts as a release when it is not overridden by a new producer.
    assign cnt_inc = rsv_ok && !pend[rsv_addr];
    assign cnt_dec = wb_ok && pend[wb_addr] && !(rsv_ok && rsv_addr == wb_addr);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_ok) set_vec[rsv_addr] = 1'b1;
        if (wb_ok)  clr_vec[wb_addr]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend <= (pend & ~clr_vec) | set_vec;
            if (cnt_inc && !cnt_dec)
                pend_cnt <= pend_cnt + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                pend_cnt <= pend_cnt - CNT_ONE;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_busy
        logic [AW-1:0] ra;
        assign ra       = raddr[p*AW +: AW];
        assign rbusy[p] = pend[ra] & ~(wb_en & (wb_addr == ra));
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with same-cycle writeback bypass and an
// integrated pending-write scoreboard used by decode for hazard stalls.
module regfile_mp_sb #(
    parameter int  XLEN     = rv_pkg::XLEN,
    parameter int  NREG     = rv_pkg::NREG,
    parameter int  NRP      = 2,
    parameter bit  ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && !(ZERO_REG && wb_addr == '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Bypass is suppressed during reset so every port reads the cleared file.
    for (genvar p = 0; p < NRP; p++) begin : g_read
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        assign ra = raddr[p*AW +: AW];

        always_comb begin
            if (ZERO_REG && ra == '0)
                rd = '0;
            else if (!rst && wb_en && wb_addr == ra)
                rd = wb_data;
            else
                rd = regs[ra];
        end

        assign rdata[p*XLEN +: XLEN] = rd;
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .NRP      (NRP),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rbusy    (rbusy),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a default 2-port/32-bit instance and a
// 4-port/64-bit/16-register instance checked against a small reference model.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: XLEN=32, NREG=32, NRP=2
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_addr;
    logic        a_wb_en;
    logic [4:0]  a_wb_addr;
    logic [31:0] a_wb_data;
    logic [5:0]  a_pend_cnt;

    // instance B: XLEN=64, NREG=16, NRP=4
    logic [15:0]  b_raddr;
    logic [255:0] b_rdata;
    logic [3:0]   b_rbusy;
    logic         b_rsv_en;
    logic [3:0]   b_rsv_addr;
    logic         b_wb_en;
    logic [3:0]   b_wb_addr;
    logic [63:0]  b_wb_data;
    logic [4:0]   b_pend_cnt;

    regfile_mp_sb dut_a (
        .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .wb_en(a_wb_en), .wb_addr(a_wb_addr),
        .wb_data(a_wb_data), .pend_cnt(a_pend_cnt)
    );

    regfile_mp_sb #(.XLEN(64), .NREG(16), .NRP(4), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .wb_en(b_wb_en), .wb_addr(b_wb_addr),
        .wb_data(b_wb_data), .pend_cnt(b_pend_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] mregs [16];
    logic        mpend [16];
    int          mcnt;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_idle();
        a_raddr = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
        a_wb_en = 1'b0; a_wb_addr = '0; a_wb_data = '0;
        b_raddr = '0; b_rsv_en = 1'b0; b_rsv_addr = '0;
        b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0;
    endtask

    task automatic apply_wb_b(input logic [3:0] addr, input logic [63:0] data);
        b_wb_en = 1'b1; b_wb_addr = addr; b_wb_data = data;
        tick();
        b_wb_en = 1'b0;
    endtask

    initial begin
        logic [3:0]  ra;
        logic [63:0] exp_d;
        logic        exp_b;

        rst = 1'b1;
        apply_idle();
        tick();
        tick();
        check_output("rst_rdata0", a_rdata[31:0], 32'h0);
        check_output("rst_rbusy", a_rbusy, 2'b00);
        check_output("rst_pend_cnt_a", a_pend_cnt, 6'd0);
        check_output("rst_pend_cnt_b", b_pend_cnt, 5'd0);
        rst = 1'b0;

        // async reset in the middle of a cycle
        a_wb_en = 1'b1; a_wb_addr = 5'd5; a_wb_data = 32'hDEADBEEF;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
        tick();
        apply_idle();
        a_raddr = {5'd6, 5'd5};
        #1;
        check_output("pre_rst_rdata_x5", a_rdata[31:0], 32'hDEADBEEF);
        check_output("pre_rst_rbusy_x6", a_rbusy[1], 1'b1);
        check_output("pre_rst_pend_cnt", a_pend_cnt, 6'd1);
        #1;
        rst = 1'b1;
        #1;
        check_output("async_rst_rdata_x5", a_rdata[31:0], 32'h0);
        check_output("async_rst_pend_cnt", a_pend_cnt, 6'd0);
        #1;
        rst = 1'b0;
        tick();
        check_output("post_rst_rdata_x5", a_rdata[31:0], 32'h0);
        check_output("post_rst_rbusy_x6", a_rbusy[1], 1'b0);
        check_output("post_rst_pend_cnt", a_pend_cnt, 6'd0);

        // zero register ignores write, reserve and bypass
        a_wb_en = 1'b1; a_wb_addr = 5'd0; a_wb_data = 32'h1234;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd0; a_raddr = {5'd0, 5'd0};
        #1;
        check_output("zero_bypass_rdata", a_rdata[31:0], 32'h0);
        check_output("zero_rbusy", a_rbusy[0], 1'b0);
        tick();
        apply_idle();
        #1;
        check_output("zero_stored_rdata", a_rdata[31:0], 32'h0);
        check_output("zero_rbusy_after", a_rbusy[0], 1'b0);
        check_output("zero_pend_cnt", a_pend_cnt, 6'd0);

        // write-to-read bypass
        a_wb_en = 1'b1; a_wb_addr = 5'd7; a_wb_data = 32'h11;
        tick();
        a_wb_data = 32'h22; a_raddr = {5'd7, 5'd7};
        #1;
        check_output("bypass_rdata0", a_rdata[31:0], 32'h22);
        check_output("bypass_rdata1", a_rdata[63:32], 32'h22);
        tick();
        a_wb_en = 1'b0;
        #1;
        check_output("bypass_stored_x7", a_rdata[31:0], 32'h22);
        a_wb_en = 1'b1; a_wb_addr = 5'd8; a_wb_data = 32'h55; a_raddr = {5'd8, 5'd7};
        #1;
        check_output("nobypass_other_x7", a_rdata[31:0], 32'h22);
        check_output("bypass_port1_x8", a_rdata[63:32], 32'h55);
        tick();
        apply_idle();

        // scoreboard reserve then release
        a_rsv_en = 1'b1; a_rsv_addr = 5'd3; a_raddr = {5'd0, 5'd3};
        #1;
        check_output("rsv_same_cycle_rbusy", a_rbusy[0], 1'b0);
        tick();
        a_rsv_en = 1'b0;
        #1;
        check_output("rsv_x3_rbusy", a_rbusy[0], 1'b1);
        check_output("rsv_x3_pend_cnt", a_pend_cnt, 6'd1);
        a_wb_en = 1'b1; a_wb_addr = 5'd3; a_wb_data = 32'h99;
        #1;
        check_output("wb_x3_rbusy_cleared", a_rbusy[0], 1'b0);
        check_output("wb_x3_rdata_bypass", a_rdata[31:0], 32'h99);
        tick();
        a_wb_en = 1'b0;
        #1;
        check_output("wb_x3_pend_cnt", a_pend_cnt, 6'd0);
        check_output("wb_x3_rbusy_after", a_rbusy[0], 1'b0);
        check_output("wb_x3_stored", a_rdata[31:0], 32'h99);

        // simultaneous reserve and writeback on a pending register
        a_rsv_en = 1'b1; a_rsv_addr = 5'd4; a_raddr = {5'd0, 5'd4};
        tick();
        a_wb_en = 1'b1; a_wb_addr = 5'd4; a_wb_data = 32'hAA;
        #1;
        check_output("simul_rbusy_bypass", a_rbusy[0], 1'b0);
        tick();
        apply_idle();
        a_raddr = {5'd0, 5'd4};
        #1;
        check_output("simul_x4_still_busy", a_rbusy[0], 1'b1);
        check_output("simul_pend_cnt", a_pend_cnt, 6'd1);
        check_output("simul_x4_written", a_rdata[31:0], 32'hAA);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
        tick();
        a_rsv_en = 1'b0;
        check_output("dup_rsv_pend_cnt", a_pend_cnt, 6'd1);
        a_wb_en = 1'b1; a_wb_addr = 5'd9; a_wb_data = 32'h77;
        tick();
        a_wb_en = 1'b0;
        check_output("wb_nonpending_pend_cnt", a_pend_cnt, 6'd1);
        a_rsv_en = 1'b1; a_rsv_addr = 5'd10; a_wb_en = 1'b1; a_wb_addr = 5'd10; a_wb_data = 32'h1;
        tick();
        apply_idle();
        check_output("simul_fresh_pend_cnt", a_pend_cnt, 6'd2);

        // four-port instance: distinct reads with a bypassed port
        apply_wb_b(4'd1, 64'h0123_4567_89AB_CDEF);
        apply_wb_b(4'd2, 64'hFEDC_BA98_7654_3210);
        apply_wb_b(4'd3, 64'h1111_2222_3333_4444);
        apply_wb_b(4'd15, 64'h5555_6666_7777_8888);
        b_wb_en = 1'b1; b_wb_addr = 4'd15; b_wb_data = 64'hCAFE_F00D_1234_5678;
        b_raddr = {4'd15, 4'd3, 4'd2, 4'd1};
        #1;
        check_output("b_port0_x1", b_rdata[63:0], 64'h0123_4567_89AB_CDEF);
        check_output("b_port1_x2", b_rdata[127:64], 64'hFEDC_BA98_7654_3210);
        check_output("b_port2_x3", b_rdata[191:128], 64'h1111_2222_3333_4444);
        check_output("b_port3_x15_bypass", b_rdata[255:192], 64'hCAFE_F00D_1234_5678);
        tick();
        apply_idle();

        for (int i = 0; i < 16; i++) begin
            mregs[i] = 64'h0;
            mpend[i] = 1'b0;
        end
        mregs[1]  = 64'h0123_4567_89AB_CDEF;
        mregs[2]  = 64'hFEDC_BA98_7654_3210;
        mregs[3]  = 64'h1111_2222_3333_4444;
        mregs[15] = 64'hCAFE_F00D_1234_5678;

        // random reserve/writeback traffic against the reference scoreboard
        for (int i = 0; i < 150; i++) begin
            b_rsv_en   = 1'($urandom_range(0, 1));
            b_rsv_addr = 4'($urandom_range(0, 15));
            b_wb_en    = ($urandom_range(0, 2) == 0);
            b_wb_addr  = 4'($urandom_range(0, 15));
            b_wb_data  = {$urandom, $urandom};
            b_raddr    = 16'($urandom);
            #1;
            for (int p = 0; p < 4; p++) begin
                ra = b_raddr[p*4 +: 4];
                if (ra == 4'd0) begin
                    exp_d = 64'h0;
                    exp_b = 1'b0;
                end else if (b_wb_en && b_wb_addr == ra) begin
                    exp_d = b_wb_data;
                    exp_b = 1'b0;
                end else begin
                    exp_d = mregs[ra];
                    exp_b = mpend[ra];
                end
                check_output($sformatf("rand%0d_rdata%0d", i, p), b_rdata[p*64 +: 64], exp_d);
                check_output($sformatf("rand%0d_rbusy%0d", i, p), b_rbusy[p], exp_b);
            end
            if (b_wb_en && b_wb_addr != 4'd0) begin
                mregs[b_wb_addr] = b_wb_data;
                mpend[b_wb_addr] = 1'b0;
            end
            if (b_rsv_en && b_rsv_addr != 4'd0)
                mpend[b_rsv_addr] = 1'b1;
            mcnt = 0;
            for (int r = 0; r < 16; r++) mcnt += int'(mpend[r]);
            tick();
            check_output($sformatf("rand%0d_pend_cnt", i), b_pend_cnt, 64'(mcnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
